f36m_cube_root: RTL and testbench



---
 rtl/f36m_cube_root_pkg.sv | 56 +++++
 rtl/f36m_frob.sv | 25 ++
 rtl/f36m_cube_root.sv | 81 ++++++++
 tb/tb_f36m_cube_root.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/f36m_cube_root_pkg.sv
// Shared constants and F_{3^m} digit helpers for the F_{3^{6m}} cube-root unit.
// F_{3^m} = F_3[x]/(x^97 + x^12 + 2); digits are 2-bit (00=0, 01=1, 10=2), digit i at bits [2i+1:2i].
package f36m_cube_root_pkg;
  localparam int M    = 97;
  localparam int W    = 2*M;      // one F_{3^m} coefficient
  localparam int W6   = 6*W;      // one F_{3^{6m}} element
  localparam int ITER = 6*M-1;
  localparam int CW   = 10;
  localparam int K    = 12;       // middle term of the field polynomial
  localparam int PD   = 3*M-2;    // digits of an unreduced cube

`ifdef F36M_CUBE_ROOT_SELF_CHECK_EN
  typedef enum logic [2:0] {IDLE, RUN, CHECK, WB, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, RUN, WB, DONE} state_t;
`endif

  function automatic logic [1:0] f3add(input logic [1:0] x, input logic [1:0] y);
    logic [2:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  function automatic logic [1:0] f3neg(input logic [1:0] x);
    return {x[0], x[1]};
  endfunction

  function automatic logic [W-1:0] f3m_add(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] s;
    s = '0;
    for (int i = 0; i < M; i++) s[2*i +: 2] = f3add(x[2*i +: 2], y[2*i +: 2]);
    return s;
  endfunction

  function automatic logic [W-1:0] f3m_neg(input logic [W-1:0] x);
    logic [W-1:0] s;
    s = '0;
    for (int i = 0; i < M; i++) s[2*i +: 2] = f3neg(x[2*i +: 2]);
    return s;
  endfunction

  // a^3 spreads digit i to degree 3i; fold high degrees with x^97 = 2x^12 + 1, top down
  function automatic logic [W-1:0] f3m_cube(input logic [W-1:0] x);
    logic [2*PD-1:0] p;
    logic [1:0]      t;
    p = '0;
    for (int i = 0; i < M; i++) p[6*i +: 2] = x[2*i +: 2];
    for (int d = PD-1; d >= M; d--) begin
      t = p[2*d +: 2];
      p[2*(d-M) +: 2]   = f3add(p[2*(d-M) +: 2], t);
      p[2*(d-M+K) +: 2] = f3add(p[2*(d-M+K) +: 2], f3neg(t));
    end
    return p[W-1:0];
  endfunction
endpackage

// File: rtl/f36m_frob.sv
// Combinational Frobenius (cube) in F_{3^{6m}} = F_{3^{2m}}[s]/(s^3 - s - 1), F_{3^{2m}} = F_{3^m}[y]/(y^2 + 1).
module f36m_frob
  import f36m_cube_root_pkg::*;
(
  input  logic [W6-1:0] a,
  output logic [W6-1:0] c
);
  logic [5:0][W-1:0] u;

  // y^3 = -y, so the y-coefficient of each F_{3^{2m}} part flips sign
  for (genvar k = 0; k < 6; k++) begin : g_coef
    if (k % 2 == 1) begin : g_y
      assign u[k] = f3m_neg(f3m_cube(a[k*W +: W]));
    end else begin : g_one
      assign u[k] = f3m_cube(a[k*W +: W]);
    end
  end

  // s^3 = s + 1, s^6 = s^2 + 2s + 1
  for (genvar i = 0; i < 2; i++) begin : g_sig
    assign c[i*W +: W]     = f3m_add(f3m_add(u[i], u[2+i]), u[4+i]);
    assign c[(2+i)*W +: W] = f3m_add(u[2+i], f3m_neg(u[4+i]));
    assign c[(4+i)*W +: W] = u[4+i];
  end
endmodule

// File: rtl/f36m_cube_root.sv
// Iterative cube root in F_{3^{6m}}: a^(1/3) = a^(3^(6m-1)), one cubing per clock.
// Optional F36M_CUBE_ROOT_SELF_CHECK_EN adds a CHECK state that re-cubes the result against the operand.
module f36m_cube_root
  import f36m_cube_root_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [W6-1:0] a,
  output logic [W6-1:0] c,
  output logic          done,
  output logic          err
);
  state_t        state_q, state_d;
  logic [W6-1:0] r, r3;
  logic [CW-1:0] cnt;
  logic          accept;

  f36m_frob u_frob (.a(r), .c(r3));

  assign accept = start && (state_q == IDLE || state_q == DONE);
  assign done   = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (start) state_d = RUN;
`ifdef F36M_CUBE_ROOT_SELF_CHECK_EN
      RUN:   if (cnt == CW'(ITER-1)) state_d = CHECK;
      CHECK: state_d = WB;
`else
      RUN:   if (cnt == CW'(ITER-1)) state_d = WB;
`endif
      WB:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // r is final after the last RUN edge; c is published on the edge entering DONE
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      r       <= '0;
      cnt     <= '0;
      c       <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        r   <= a;
        cnt <= '0;
      end else if (state_q == RUN) begin
        r   <= r3;
        cnt <= (cnt == CW'(ITER-1)) ? '0 : cnt + 1'b1;
      end
      if (state_q == WB) c <= r;
    end
  end

`ifdef F36M_CUBE_ROOT_SELF_CHECK_EN
  logic [W6-1:0] a_q, r3c;
  logic          err_q;

  f36m_frob u_chk (.a(r), .c(r3c));

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q   <= '0;
      err_q <= 1'b0;
    end else if (accept) begin
      a_q   <= a;
      err_q <= 1'b0;
    end else if (state_q == CHECK) begin
      err_q <= (r3c != a_q);
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_f36m_cube_root.sv
// Directed bench for f36m_cube_root: latency, known vectors, busy/back-to-back starts, mid-run reset.
module tb_f36m_cube_root;
  import f36m_cube_root_pkg::*;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [W6-1:0] a, c;
  logic          done, err;
  int            total = 0;
  int            bad   = 0;

`ifdef F36M_CUBE_ROOT_SELF_CHECK_EN
  localparam int LAT = 583;
`else
  localparam int LAT = 582;
`endif

  localparam logic [W6-1:0] ZERO = '0;
  localparam logic [W6-1:0] ONE  = {{5{194'h0}}, 194'h1};
  localparam logic [W6-1:0] MONE = {{5{194'h0}}, 194'h2};
  localparam logic [W6-1:0] KA = {
    194'ha9926611a84a4114aa562246626418486540006a4829a014, 194'h8644a469852659949412582a1a262145524206028042690a,
    194'h2585255021628414524615aa156881a642605a0a446018622, 194'haaa8806216a0555a04194a2110464440a2964246a56a1020,
    194'h14092128882119a9a050a6149146a21810891996014002449, 194'h14980a940a502a4821852486460690605815894849aa20a08};
  localparam logic [W6-1:0] KC = {
    194'h225016412804a89a862aa1865268898886919259910155856, 194'h10258285148a0048861944a264aa161a048829812a1961218,
    194'ha9a29a12069660862a6a651806416061940925809115510a, 194'h4115a2024962a809a065428aa6088668249a2890a5518a69,
    194'h12918199902558a859412a9596148a00520685401210a95a8, 194'h1505090561625145816a11225085092955995885598049126};

  f36m_cube_root dut (.clk(clk), .reset(reset), .start(start), .a(a), .c(c), .done(done), .err(err));

  always #5 clk = ~clk;

  // first differing 194-bit coefficient, so FAIL lines stay short
  function automatic int fd(input logic [W6-1:0] x, input logic [W6-1:0] y);
    for (int k = 0; k < 6; k++) if (x[k*W +: W] !== y[k*W +: W]) return k;
    return 0;
  endfunction

  task automatic pulse_start(input logic [W6-1:0] v);
    a = v; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < LAT + 50) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; a = KA;
    repeat (2) @(posedge clk);
    #1;
    total++; if (c !== ZERO) begin bad++; $display("FAIL reset_c got %h want 0", c[W-1:0]); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got %b want 0", done); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got %b want 0", err); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_zero;
    int n, k;
    pulse_start(ZERO);
    wait_done(n);
    k = fd(c, ZERO);
    total++; if (n !== LAT) begin bad++; $display("FAIL zero_latency got %0d want %0d", n, LAT); end
    total++; if (c !== ZERO) begin bad++; $display("FAIL zero_c coef%0d got %h want %h", k, c[k*W +: W], ZERO[k*W +: W]); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL zero_err got %b want 0", err); end
  endtask

  task automatic test_one;
    int n, k;
    pulse_start(ONE);
    wait_done(n);
    k = fd(c, ONE);
    total++; if (n !== LAT) begin bad++; $display("FAIL one_latency got %0d want %0d", n, LAT); end
    total++; if (c !== ONE) begin bad++; $display("FAIL one_c coef%0d got %h want %h", k, c[k*W +: W], ONE[k*W +: W]); end
    pulse_start(MONE);
    wait_done(n);
    k = fd(c, MONE);
    total++; if (n !== LAT) begin bad++; $display("FAIL mone_latency got %0d want %0d", n, LAT); end
    total++; if (c !== MONE) begin bad++; $display("FAIL mone_c coef%0d got %h want %h", k, c[k*W +: W], MONE[k*W +: W]); end
  endtask

  task automatic test_known;
    int n, k;
    pulse_start(KA);
    total++; if (c !== MONE) begin bad++; $display("FAIL known_hold_prev got %h want %h", c[W-1:0], MONE[W-1:0]); end
    wait_done(n);
    k = fd(c, KC);
    total++; if (n !== LAT) begin bad++; $display("FAIL known_latency got %0d want %0d", n, LAT); end
    total++; if (c !== KC) begin bad++; $display("FAIL known_c coef%0d got %h want %h", k, c[k*W +: W], KC[k*W +: W]); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL known_err got %b want 0", err); end
  endtask

  task automatic test_busy;
    int n, k;
    pulse_start(ZERO);
    wait_done(n);
    pulse_start(KA);
    repeat (99) @(posedge clk);
    #1;
    pulse_start(ONE);
    wait_done(n);
    n = n + 100;
    k = fd(c, KC);
    total++; if (n !== LAT) begin bad++; $display("FAIL busy_latency got %0d want %0d", n, LAT); end
    total++; if (c !== KC) begin bad++; $display("FAIL busy_c coef%0d got %h want %h", k, c[k*W +: W], KC[k*W +: W]); end
  endtask

  task automatic test_back_to_back;
    int n, k;
    pulse_start(MONE);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL b2b_done_drop got %b want 0", done); end
    total++; if (c !== KC) begin bad++; $display("FAIL b2b_hold_prev got %h want %h", c[W-1:0], KC[W-1:0]); end
    wait_done(n);
    k = fd(c, MONE);
    total++; if (n !== LAT) begin bad++; $display("FAIL b2b_latency got %0d want %0d", n, LAT); end
    total++; if (c !== MONE) begin bad++; $display("FAIL b2b_c coef%0d got %h want %h", k, c[k*W +: W], MONE[k*W +: W]); end
  endtask

  task automatic test_reset_mid_run;
    int n, k, seen;
    pulse_start(KA);
    repeat (299) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    total++; if (c !== ZERO) begin bad++; $display("FAIL midrst_c got %h want 0", c[W-1:0]); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL midrst_done got %b want 0", done); end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL midrst_idle got %0d done cycles want 0", seen); end
    pulse_start(ONE);
    wait_done(n);
    k = fd(c, ONE);
    total++; if (n !== LAT) begin bad++; $display("FAIL midrst_latency got %0d want %0d", n, LAT); end
    total++; if (c !== ONE) begin bad++; $display("FAIL midrst_c_after coef%0d got %h want %h", k, c[k*W +: W], ONE[k*W +: W]); end
  endtask

`ifdef F36M_CUBE_ROOT_SELF_CHECK_EN
  task automatic test_self_check;
    int n;
    pulse_start(KA);
    repeat (199) @(posedge clk);
    #1;
    force dut.r = ONE;
    @(posedge clk); #1;
    release dut.r;
    wait_done(n);
    n = n + 200;
    total++; if (n !== LAT) begin bad++; $display("FAIL selfchk_latency got %0d want %0d", n, LAT); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL selfchk_err got %b want 1", err); end
    pulse_start(KA);
    wait_done(n);
    total++; if (err !== 1'b0) begin bad++; $display("FAIL selfchk_clean_err got %b want 0", err); end
  endtask
`endif

  initial begin
    reset = 1'b1; start = 1'b0; a = '0;
    test_reset();
    test_zero();
    test_one();
    test_known();
    test_busy();
    test_back_to_back();
    test_reset_mid_run();
`ifdef F36M_CUBE_ROOT_SELF_CHECK_EN
    test_self_check();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
